mem_port_arbiter: RTL

//  Shares the single line-wide memory port between ICache refill (read-only) and DCache (read/write).

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared line-wide memory port between ICache refill (read-only)
// and DCache (read/write), with a saturating wait-cycle counter for each requester.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int LINE_WIDTH    = 64,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_WIDTH-1:0]    i_addr,
   input  logic                     i_read_en,
   output logic                     i_done,
   output logic [LINE_WIDTH-1:0]    i_read_value,
   input  logic [ADDR_WIDTH-1:0]    d_addr,
   input  logic                     d_read_en,
   input  logic                     d_write_en,
   input  logic [LINE_WIDTH-1:0]    d_write_value,
   output logic                     d_done,
   output logic [LINE_WIDTH-1:0]    d_read_value,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic                     mem_read_en,
   output logic                     mem_write_en,
   output logic [LINE_WIDTH-1:0]    mem_write_value,
   input  logic                     mem_done,
   input  logic [LINE_WIDTH-1:0]    mem_read_value,
   output logic [1:0]               owner,
   output logic [COUNTER_WIDTH-1:0] i_wait_count,
   output logic [COUNTER_WIDTH-1:0] d_wait_count
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURNAROUND} state_t;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I    = 2'd1;
   localparam logic [1:0] OWNER_D    = 2'd2;

   state_t                   state_q;
   logic                     lastGrantD_q;
   logic                     regWrite_q;
   logic [1:0]               owner_q;
   logic [ADDR_WIDTH-1:0]    memAddr_q;
   logic [LINE_WIDTH-1:0]    memWriteValue_q;
   logic [COUNTER_WIDTH-1:0] iWait_q;
   logic [COUNTER_WIDTH-1:0] iWait_d;
   logic [COUNTER_WIDTH-1:0] dWait_q;
   logic [COUNTER_WIDTH-1:0] dWait_d;
   logic                     iReq;
   logic                     dReq;
   logic                     grantI;

   assign iReq   = i_read_en;
   assign dReq   = d_read_en | d_write_en;
   // ICache takes the port when DCache is quiet or DCache held the previous grant
   assign grantI = iReq & (~dReq | lastGrantD_q);

   // Grant FSM: owner, address and write data are captured at the grant edge and held
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         lastGrantD_q    <= 1'b1;
         regWrite_q      <= 1'b0;
         owner_q         <= OWNER_NONE;
         memAddr_q       <= '0;
         memWriteValue_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantI) begin
                  state_q      <= GRANT_I;
                  owner_q      <= OWNER_I;
                  memAddr_q    <= i_addr;
                  regWrite_q   <= 1'b0;
                  lastGrantD_q <= 1'b0;
               end else if (dReq) begin
                  state_q         <= GRANT_D;
                  owner_q         <= OWNER_D;
                  memAddr_q       <= d_addr;
                  memWriteValue_q <= d_write_value;
                  regWrite_q      <= d_write_en;
                  lastGrantD_q    <= 1'b1;
               end
            end
            GRANT_I, GRANT_D: begin
               if (mem_done) begin
                  state_q <= TURNAROUND;
                  owner_q <= OWNER_NONE;
               end
            end
            TURNAROUND: state_q <= IDLE;
            default:    state_q <= IDLE;
         endcase
      end
   end

   assign mem_read_en     = (state_q == GRANT_I) | ((state_q == GRANT_D) & ~regWrite_q);
   assign mem_write_en    = (state_q == GRANT_D) & regWrite_q;
   assign mem_addr        = memAddr_q;
   assign mem_write_value = memWriteValue_q;
   assign owner           = owner_q;

   assign i_done       = ~rst & mem_done & (state_q == GRANT_I);
   assign d_done       = ~rst & mem_done & (state_q == GRANT_D);
   assign i_read_value = mem_read_value;
   assign d_read_value = mem_read_value;

   // Wait counters advance while a request is pending and someone else (or nobody) owns the port
   always_comb begin
      iWait_d = iWait_q;
      dWait_d = dWait_q;
      if (iReq && (owner_q != OWNER_I) && (iWait_q != '1)) begin
         iWait_d = iWait_q + COUNTER_WIDTH'(1);
      end
      if (dReq && (owner_q != OWNER_D) && (dWait_q != '1)) begin
         dWait_d = dWait_q + COUNTER_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iWait_q <= '0;
         dWait_q <= '0;
      end else begin
         iWait_q <= iWait_d;
         dWait_q <= dWait_d;
      end
   end

   assign i_wait_count = iWait_q;
   assign d_wait_count = dWait_q;

endmodule
